// File: rtl/servo_seq_pkg.sv
// Shared definitions for the Wishbone servo sequencer: register map,
// command word layout, width limits and sequencer states.
package servo_seq_pkg;

   localparam logic [3:0] ADR_CMD        = 4'd0;
   localparam logic [3:0] ADR_STATUS     = 4'd1;
   localparam logic [3:0] ADR_CTRL       = 4'd2;
   localparam logic [3:0] ADR_WIDTH_BASE = 4'd8;

   localparam int CMD_CH_LSB   = 0;
   localparam int CMD_W_LSB    = 4;
   localparam int CMD_HOLD_LSB = 16;
   localparam int CH_W         = 3;
   localparam int WIDTH_W      = 12;
   localparam int HOLD_W       = 16;
   localparam int ENTRY_W      = CH_W + WIDTH_W + HOLD_W;

   localparam int CTRL_RUN     = 0;
   localparam int CTRL_IRQ_EN  = 1;
   localparam int CTRL_FLUSH   = 2;
   localparam int CTRL_CLR_OVF = 3;

   localparam logic [WIDTH_W-1:0] WIDTH_MIN = 12'd500;
   localparam logic [WIDTH_W-1:0] WIDTH_MAX = 12'd2500;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_HOLD = 2'd2
   } seq_state_t;

   typedef struct packed {
      logic [HOLD_W-1:0]  hold_ms;
      logic [WIDTH_W-1:0] width_us;
      logic [CH_W-1:0]    ch;
   } servo_cmd_t;

   // Zero means "channel off" and passes through; anything else is held
   // inside the range a standard hobby servo accepts.
   function automatic logic [WIDTH_W-1:0] clamp_width(input logic [WIDTH_W-1:0] w);
      if (w == '0)            return '0;
      else if (w < WIDTH_MIN) return WIDTH_MIN;
      else if (w > WIDTH_MAX) return WIDTH_MAX;
      return w;
   endfunction

endpackage

// File: rtl/wb_servo_seq_fifo.sv
// Generic synchronous FIFO with flush and occupancy level. A push into a
// full FIFO is only accepted when a pop frees a slot in the same cycle.
module sync_fifo #(
   parameter int WIDTH = 31,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_push,
   input  logic                     i_pop,
   input  logic                     i_flush,
   input  logic [WIDTH-1:0]         i_data,
   output logic [WIDTH-1:0]         o_data,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_level
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_level;
   logic             w_do_push;
   logic             w_do_pop;

   assign o_empty   = (r_level == '0);
   assign o_full    = (r_level == (AW+1)'(DEPTH));
   assign o_level   = r_level;
   assign o_data    = r_mem[r_rd_ptr];
   assign w_do_pop  = i_pop & ~o_empty;
   assign w_do_push = i_push & (~o_full | w_do_pop);

   // Storage array; no reset needed since pointers gate every read.
   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= i_data;
   end

   // Pointers and level; flush discards everything in one cycle.
   always_ff @(posedge clk) begin
      if (rst || i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_do_push, w_do_pop})
            2'b10:   r_level <= r_level + 1'b1;
            2'b01:   r_level <= r_level - 1'b1;
            default: r_level <= r_level;
         endcase
      end
   end

endmodule

// File: rtl/wb_servo_seq.sv
// Wishbone servo sequencer: queues timed move commands and replays them,
// driving 8 servo pulse trains on a fixed frame period.
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | waiting for run with a queued command; pop on exit
// LOAD    | write pending width of the popped channel, load hold
// HOLD    | count hold_ms down on ms ticks, return to IDLE at zero
module wb_servo_seq
   import servo_seq_pkg::*;
#(
   parameter int CLK_FREQ   = 100000000,
   parameter int FIFO_DEPTH = 16,
   parameter int PERIOD_US  = 20000,
   parameter int N_CH       = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] wb_adr_i,
   input  logic [31:0] wb_dat_i,
   output logic [31:0] wb_dat_o,
   input  logic [3:0]  wb_sel_i,
   input  logic        wb_we_i,
   input  logic        wb_cyc_i,
   input  logic        wb_stb_i,
   output logic        wb_ack_o,
   output logic [7:0]  servo_o,
   output logic        irq
);
   localparam int CYC_PER_US = CLK_FREQ / 1000000;
   localparam int DIV_W      = (CYC_PER_US > 1) ? $clog2(CYC_PER_US) : 1;
   localparam int FRAME_W    = $clog2(PERIOD_US + 1);
   localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1;

   logic                r_ack;
   logic [31:0]         r_dat;
   logic                r_run;
   logic                r_irq_en;
   logic                r_ovf;
   seq_state_t          r_state;
   seq_state_t          w_state_nxt;
   servo_cmd_t          r_cmd;
   logic [HOLD_W-1:0]   r_hold_cnt;
   logic [DIV_W-1:0]    r_us_div;
   logic [9:0]          r_ms_div;
   logic [FRAME_W-1:0]  r_frame_us;
   logic [WIDTH_W-1:0]  r_pending [N_CH];
   logic [WIDTH_W-1:0]  r_width   [N_CH];
   logic [7:0]          r_servo;

   logic                w_req;
   logic [3:0]          w_off;
   logic                w_push;
   logic                w_ctrl_wr;
   logic                w_flush;
   logic                w_clr_ovf;
   logic                w_pop;
   logic                w_full;
   logic                w_empty;
   logic [LVL_W-1:0]    w_level;
   logic                w_drop;
   servo_cmd_t          w_fifo_din;
   servo_cmd_t          w_fifo_dout;
   logic [31:0]         w_rdata;
   logic                w_us_tick;
   logic                w_ms_tick;
   logic                w_frame_wrap;
   logic                w_unused;

   assign w_unused  = ^{wb_adr_i[31:6], wb_adr_i[1:0], wb_sel_i};

   assign w_req     = wb_cyc_i & wb_stb_i & ~r_ack;
   assign w_off     = wb_adr_i[5:2];
   assign w_push    = w_req & wb_we_i & (w_off == ADR_CMD);
   assign w_ctrl_wr = w_req & wb_we_i & (w_off == ADR_CTRL);
   assign w_flush   = w_ctrl_wr & wb_dat_i[CTRL_FLUSH];
   assign w_clr_ovf = w_ctrl_wr & wb_dat_i[CTRL_CLR_OVF];
   assign w_drop    = w_push & w_full & ~w_pop;

   assign w_fifo_din.ch       = wb_dat_i[CMD_CH_LSB +: CH_W];
   assign w_fifo_din.width_us = clamp_width(wb_dat_i[CMD_W_LSB +: WIDTH_W]);
   assign w_fifo_din.hold_ms  = wb_dat_i[CMD_HOLD_LSB +: HOLD_W];

   sync_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_flush (w_flush),
      .i_data  (w_fifo_din),
      .o_data  (w_fifo_dout),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_level (w_level)
   );

   // Register read mux; unmapped offsets read zero.
   always_comb begin
      w_rdata = '0;
      case (w_off)
         ADR_STATUS: w_rdata = {21'd0, r_ovf, 7'(w_level), w_empty, w_full,
                                (r_state != ST_IDLE)};
         ADR_CTRL:   w_rdata = {30'd0, r_irq_en, r_run};
         default:    if (w_off[3]) w_rdata = {20'd0, r_width[w_off[2:0]]};
      endcase
   end

   // Single-cycle ack one clock after the request; data valid with ack.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ack <= 1'b0;
         r_dat <= '0;
      end else begin
         r_ack <= w_req;
         r_dat <= (w_req && !wb_we_i) ? w_rdata : '0;
      end
   end

   // Control bits and sticky overflow flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_run    <= 1'b0;
         r_irq_en <= 1'b0;
         r_ovf    <= 1'b0;
      end else begin
         if (w_ctrl_wr) begin
            r_run    <= wb_dat_i[CTRL_RUN];
            r_irq_en <= wb_dat_i[CTRL_IRQ_EN];
         end
         if (w_drop)         r_ovf <= 1'b1;
         else if (w_clr_ovf) r_ovf <= 1'b0;
      end
   end

   assign w_us_tick    = (r_us_div == '0);
   assign w_ms_tick    = w_us_tick & (r_ms_div == '0);
   assign w_frame_wrap = w_us_tick & (r_frame_us == FRAME_W'(PERIOD_US - 1));

   // Microsecond and millisecond down-counters plus the frame position.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_us_div   <= DIV_W'(CYC_PER_US - 1);
         r_ms_div   <= 10'd999;
         r_frame_us <= '0;
      end else begin
         r_us_div <= w_us_tick ? DIV_W'(CYC_PER_US - 1) : r_us_div - 1'b1;
         if (w_us_tick) begin
            r_ms_div   <= (r_ms_div == '0) ? 10'd999 : r_ms_div - 1'b1;
            r_frame_us <= w_frame_wrap ? '0 : r_frame_us + 1'b1;
         end
      end
   end

   // Sequencer state, popped command and hold timer.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_cmd      <= '0;
         r_hold_cnt <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_pop) r_cmd <= w_fifo_dout;
         if (r_state == ST_LOAD)
            r_hold_cnt <= r_cmd.hold_ms;
         else if (r_state == ST_HOLD && w_ms_tick && r_hold_cnt != '0)
            r_hold_cnt <= r_hold_cnt - 1'b1;
      end
   end

   // Next-state logic; the pop coincides with leaving IDLE.
   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      case (r_state)
         ST_IDLE: if (r_run && !w_empty) begin
            w_pop       = 1'b1;
            w_state_nxt = ST_LOAD;
         end
         ST_LOAD: w_state_nxt = ST_HOLD;
         ST_HOLD: if (r_hold_cnt == '0) w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Pending widths take commands; committed widths only move at frame start
   // so a pulse in progress is never cut short or stretched.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < N_CH; i++) begin
            r_pending[i] <= '0;
            r_width[i]   <= '0;
         end
      end else begin
         if (r_state == ST_LOAD) r_pending[r_cmd.ch] <= r_cmd.width_us;
         if (w_frame_wrap) begin
            for (int i = 0; i < N_CH; i++) r_width[i] <= r_pending[i];
         end
      end
   end

   // Registered pulse outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_servo <= '0;
      end else begin
         for (int i = 0; i < N_CH; i++)
            r_servo[i] <= (32'(r_frame_us) < 32'(r_width[i]));
      end
   end

   assign wb_ack_o = r_ack;
   assign wb_dat_o = r_dat;
   assign servo_o  = r_servo;
   assign irq      = r_irq_en & r_run & w_empty & (r_state == ST_IDLE);

endmodule

// File: tb/tb_wb_servo_seq.sv
// Directed bench for wb_servo_seq at 2 MHz with a 3000 us frame
// (6000 clocks per frame, 2 clocks per microsecond).
module tb_wb_servo_seq;
   localparam int CLK_FREQ   = 2000000;
   localparam int FIFO_DEPTH = 16;
   localparam int PERIOD_US  = 3000;
   localparam int N_CH       = 8;
   localparam int FRAME_CYC  = 6000;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] wb_adr_i;
   logic [31:0] wb_dat_i;
   logic [31:0] wb_dat_o;
   logic [3:0]  wb_sel_i;
   logic        wb_we_i;
   logic        wb_cyc_i;
   logic        wb_stb_i;
   logic        wb_ack_o;
   logic [7:0]  servo_o;
   logic        irq;

   int errors = 0;
   int checks = 0;
   int cnt [N_CH];
   logic next_high;

   wb_servo_seq #(
      .CLK_FREQ   (CLK_FREQ),
      .FIFO_DEPTH (FIFO_DEPTH),
      .PERIOD_US  (PERIOD_US),
      .N_CH       (N_CH)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .wb_adr_i (wb_adr_i),
      .wb_dat_i (wb_dat_i),
      .wb_dat_o (wb_dat_o),
      .wb_sel_i (wb_sel_i),
      .wb_we_i  (wb_we_i),
      .wb_cyc_i (wb_cyc_i),
      .wb_stb_i (wb_stb_i),
      .wb_ack_o (wb_ack_o),
      .servo_o  (servo_o),
      .irq      (irq)
   );

   always #5 clk = ~clk;

   task automatic bus_access(input logic we, input logic [3:0] off, input logic [31:0] wdat,
                             output logic [31:0] rdat, output int lat);
      @(posedge clk); #1;
      wb_adr_i = {26'd0, off, 2'b00};
      wb_dat_i = wdat;
      wb_we_i  = we;
      wb_sel_i = 4'hf;
      wb_cyc_i = 1'b1;
      wb_stb_i = 1'b1;
      lat  = 0;
      rdat = '0;
      for (int k = 1; k <= 8; k++) begin
         @(posedge clk); #1;
         if (wb_ack_o) begin
            lat  = k;
            rdat = wb_dat_o;
            break;
         end
      end
      wb_cyc_i = 1'b0;
      wb_stb_i = 1'b0;
      wb_we_i  = 1'b0;
      if (lat == 0) begin
         checks++; errors++;
         $display("FAIL bus_timeout off=%0d: no ack within 8 cycles", off);
      end
   endtask

   task automatic wb_write(input logic [3:0] off, input logic [31:0] d);
      logic [31:0] dummy;
      int lat;
      bus_access(1'b1, off, d, dummy, lat);
   endtask

   task automatic wb_read(input logic [3:0] off, output logic [31:0] d);
      int lat;
      bus_access(1'b0, off, 32'd0, d, lat);
   endtask

   function automatic logic [31:0] cmd(input int ch, input int w, input int h);
      return {h[15:0], w[11:0], 1'b0, ch[2:0]};
   endfunction

   task automatic wait_idle();
      logic [31:0] st;
      bit done = 0;
      for (int k = 0; k < 100 && !done; k++) begin
         wb_read(4'd1, st);
         if (st[0] == 1'b0) done = 1;
      end
      if (!done) begin
         checks++; errors++;
         $display("FAIL wait_idle: sequencer still busy after 100 polls");
      end
   endtask

   // Wait for a full pulse start on channel ch, then count high samples of
   // every channel over exactly one frame; next_high is the sample one
   // frame after the rising edge.
   task automatic measure_frame(input int ch);
      bit ok = 0;
      for (int i = 0; i < N_CH; i++) cnt[i] = 0;
      next_high = 1'b0;
      for (int k = 0; k < FRAME_CYC + 20 && !ok; k++) begin
         @(posedge clk); #1;
         if (!servo_o[ch]) ok = 1;
      end
      if (ok) begin
         ok = 0;
         for (int k = 0; k < 2 * FRAME_CYC && !ok; k++) begin
            @(posedge clk); #1;
            if (servo_o[ch]) ok = 1;
         end
      end
      if (!ok) begin
         checks++; errors++;
         $display("FAIL measure_timeout ch=%0d: no pulse edge seen", ch);
         return;
      end
      for (int k = 0; k < FRAME_CYC; k++) begin
         if (k > 0) begin @(posedge clk); #1; end
         for (int i = 0; i < N_CH; i++) cnt[i] += int'(servo_o[i]);
      end
      @(posedge clk); #1;
      next_high = servo_o[ch];
   endtask

   task automatic test_reset();
      logic [31:0] d;
      int lat;
      int highs = 0;
      rst = 1'b1;
      repeat (5) @(posedge clk);
      #1 rst = 1'b0;
      checks++; if (servo_o !== 8'h00) begin errors++; $display("FAIL reset_servo got=%h exp=00", servo_o); end
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got=%b exp=0", irq); end
      checks++; if (wb_ack_o !== 1'b0) begin errors++; $display("FAIL reset_ack got=%b exp=0", wb_ack_o); end
      checks++; if (wb_dat_o !== 32'h0) begin errors++; $display("FAIL reset_dat got=%h exp=0", wb_dat_o); end
      bus_access(1'b0, 4'd1, 32'd0, d, lat);
      checks++; if (d !== 32'h4) begin errors++; $display("FAIL reset_status got=%h exp=00000004", d); end
      checks++; if (lat !== 1) begin errors++; $display("FAIL ack_latency got=%0d exp=1", lat); end
      @(posedge clk); #1;
      checks++; if (wb_ack_o !== 1'b0) begin errors++; $display("FAIL ack_one_cycle got=%b exp=0", wb_ack_o); end
      for (int k = 0; k < 500; k++) begin
         @(posedge clk); #1;
         if (servo_o !== 8'h00) highs++;
      end
      checks++; if (highs !== 0) begin errors++; $display("FAIL reset_servo_quiet high_cycles=%0d exp=0", highs); end
      wb_read(4'd2, d);
      checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_ctrl got=%h exp=0", d); end
      wb_read(4'd11, d);
      checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_width3 got=%h exp=0", d); end
      wb_read(4'd5, d);
      checks++; if (d !== 32'h0) begin errors++; $display("FAIL unmapped_read got=%h exp=0", d); end
   endtask

   task automatic test_clamp_low();
      logic [31:0] d;
      wb_write(4'd2, 32'h1);
      wb_write(4'd0, cmd(3, 300, 0));
      wait_idle();
      measure_frame(3);
      checks++; if (cnt[3] !== 1000) begin errors++; $display("FAIL clamp_low_pulse ch3 high=%0d exp=1000", cnt[3]); end
      checks++; if (next_high !== 1'b1) begin errors++; $display("FAIL frame_period ch3 high_at_6000=%b exp=1", next_high); end
      wb_read(4'd11, d);
      checks++; if (d !== 32'd500) begin errors++; $display("FAIL clamp_low_width got=%0d exp=500", d); end
   endtask

   task automatic test_mid_frame();
      logic [31:0] d;
      wb_write(4'd0, cmd(1, 2000, 0));
      wb_write(4'd0, cmd(2, 3000, 0));
      wait_idle();
      wb_read(4'd9, d);
      checks++; if (d !== 32'd0) begin errors++; $display("FAIL mid_frame_width1 got=%0d exp=0", d); end
      checks++; if (servo_o[1] !== 1'b0) begin errors++; $display("FAIL mid_frame_servo1 got=%b exp=0", servo_o[1]); end
      measure_frame(1);
      checks++; if (cnt[1] !== 4000) begin errors++; $display("FAIL width2000_pulse high=%0d exp=4000", cnt[1]); end
      checks++; if (cnt[2] !== 5000) begin errors++; $display("FAIL clamp_high_pulse high=%0d exp=5000", cnt[2]); end
      checks++; if (cnt[3] !== 1000) begin errors++; $display("FAIL ch3_steady high=%0d exp=1000", cnt[3]); end
      wb_read(4'd10, d);
      checks++; if (d !== 32'd2500) begin errors++; $display("FAIL clamp_high_width got=%0d exp=2500", d); end
   endtask

   task automatic test_last_wins();
      wb_write(4'd0, cmd(1, 700, 0));
      wb_write(4'd0, cmd(1, 800, 0));
      wb_write(4'd0, cmd(2, 0, 0));
      wait_idle();
      measure_frame(1);
      checks++; if (cnt[1] !== 1600) begin errors++; $display("FAIL last_wins_pulse high=%0d exp=1600", cnt[1]); end
      checks++; if (cnt[2] !== 0) begin errors++; $display("FAIL width0_off high=%0d exp=0", cnt[2]); end
      checks++; if (cnt[0] !== 0) begin errors++; $display("FAIL ch0_idle high=%0d exp=0", cnt[0]); end
   endtask

   task automatic test_overflow();
      logic [31:0] d;
      wb_write(4'd2, 32'h0);
      wait_idle();
      for (int i = 0; i < 17; i++) wb_write(4'd0, cmd(0, 600, 1));
      wb_read(4'd1, d);
      checks++; if (d !== 32'h482) begin errors++; $display("FAIL overflow_status got=%h exp=00000482", d); end
      wb_write(4'd2, 32'h8);
      wb_read(4'd1, d);
      checks++; if (d !== 32'h082) begin errors++; $display("FAIL clr_ovf_status got=%h exp=00000082", d); end
      wb_write(4'd2, 32'h4);
      wb_read(4'd1, d);
      checks++; if (d !== 32'h004) begin errors++; $display("FAIL flush_status got=%h exp=00000004", d); end
      wb_read(4'd2, d);
      checks++; if (d !== 32'h0) begin errors++; $display("FAIL ctrl_pulse_bits got=%h exp=0", d); end
   endtask

   task automatic test_irq_drain();
      logic [31:0] d;
      int n = 0;
      bit seen = 0;
      wb_write(4'd2, 32'h2);
      wb_write(4'd0, cmd(0, 600, 2));
      wb_write(4'd0, cmd(0, 0, 0));
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_run_off got=%b exp=0", irq); end
      wb_read(4'd1, d);
      checks++; if (d !== 32'h10) begin errors++; $display("FAIL queued_status got=%h exp=00000010", d); end
      wb_write(4'd2, 32'h3);
      wb_read(4'd1, d);
      checks++; if (d !== 32'h9) begin errors++; $display("FAIL busy_status got=%h exp=00000009", d); end
      for (int k = 0; k < 6000 && !seen; k++) begin
         @(posedge clk); #1;
         n++;
         if (irq) seen = 1;
      end
      checks++; if (!seen || n < 1900 || n > 4100) begin errors++; $display("FAIL irq_drain_time cycles=%0d seen=%0d exp=1900..4100", n, seen); end
      wb_read(4'd1, d);
      checks++; if (d !== 32'h4) begin errors++; $display("FAIL drained_status got=%h exp=00000004", d); end
      repeat (FRAME_CYC + 100) @(posedge clk);
      #1;
      wb_read(4'd8, d);
      checks++; if (d !== 32'h0) begin errors++; $display("FAIL final_width0 got=%0d exp=0", d); end
      checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_level_hold got=%b exp=1", irq); end
      wb_write(4'd2, 32'h1);
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_en_off got=%b exp=0", irq); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] d;
      bit seen = 0;
      wb_write(4'd2, 32'h0);
      wb_write(4'd0, cmd(5, 1000, 5));
      wb_write(4'd0, cmd(6, 1000, 0));
      wb_write(4'd2, 32'h3);
      wb_read(4'd1, d);
      checks++; if (d !== 32'h9) begin errors++; $display("FAIL pre_reset_status got=%h exp=00000009", d); end
      for (int k = 0; k < FRAME_CYC + 100 && !seen; k++) begin
         @(posedge clk); #1;
         if (servo_o[3]) seen = 1;
      end
      checks++; if (!seen) begin errors++; $display("FAIL pre_reset_pulse got=0 exp=1"); end
      rst = 1'b1;
      @(posedge clk); #1;
      checks++; if (servo_o !== 8'h00) begin errors++; $display("FAIL mid_reset_servo got=%h exp=00", servo_o); end
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL mid_reset_irq got=%b exp=0", irq); end
      rst = 1'b0;
      wb_read(4'd1, d);
      checks++; if (d !== 32'h4) begin errors++; $display("FAIL post_reset_status got=%h exp=00000004", d); end
      wb_read(4'd11, d);
      checks++; if (d !== 32'h0) begin errors++; $display("FAIL post_reset_width3 got=%0d exp=0", d); end
      wb_read(4'd2, d);
      checks++; if (d !== 32'h0) begin errors++; $display("FAIL post_reset_ctrl got=%h exp=0", d); end
   endtask

   initial begin
      rst      = 1'b1;
      wb_adr_i = '0;
      wb_dat_i = '0;
      wb_sel_i = 4'h0;
      wb_we_i  = 1'b0;
      wb_cyc_i = 1'b0;
      wb_stb_i = 1'b0;
      test_reset();
      test_clamp_low();
      test_mid_frame();
      test_last_wins();
      test_overflow();
      test_irq_drain();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
